alu_sequencer: RTL and testbench
================================

// Module: alu_sequencer
// PURPOSE
//  Initiator side of the ALU operand/op interface. Accepts one operation request
//  (2-bit control class + 6-bit funct + two operands) via valid/ready, decodes it
//  to the 3-bit ALU op code, drives the combinational ALU for one cycle, captures
//  its result and returns it with Zero/Error flags via valid/ready with backpressure.
// PARAMETERS
//  WIDTH   32   operand/result width; must match the ALU datapath
//  CNT_W   16   width of completed-operation counter
// PORTS
//  clk       in   1      single clock, rising edge
//  rst_n     in   1      asynchronous reset, active-low
//  InValid   in   1      request valid
//  InReady   out  1      request accepted when InValid&InReady at clk edge
//  CtrlOp    in   2      00=add (load/store), 01=sub (branch), 10=R-type (use Funct), 11=illegal
//  Funct     in   6      R-type function field
//  InA       in   WIDTH  operand 1
//  InB       in   WIDTH  operand 2
//  AluOp     out  3      op code to ALU: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
//  AluA      out  WIDTH  registered operand 1 to ALU
//  AluB      out  WIDTH  registered operand 2 to ALU
//  AluRes    in   WIDTH  combinational ALU result
//  OutValid  out  1      result valid; held until OutValid&OutReady at clk edge
//  OutReady  in   1      downstream ready
//  Result    out  WIDTH  captured result (0 on Error)
//  Zero      out  1      Result==0 (0 on Error)
//  Error     out  1      illegal CtrlOp/Funct for this transaction
//  OpCount   out  CNT_W  count of legal operations completed (handshaken out)
// BEHAVIOUR
//  Reset (rst_n=0, async): state=IDLE; InReady=0 until first edge after release, then 1;
//   AluOp=010, AluA=AluB=0, OutValid=0, Result=0, Zero=0, Error=0, OpCount=0.
//  Decode: CtrlOp 00->010, 01->110, 10 with Funct 0x20->010, 0x22->110, 0x24->000,
//   0x25->001, 0x2A->111; CtrlOp 11 or any other Funct -> illegal.
//  FSM IDLE/ISSUE/DONE; InReady=1 only in IDLE; OutValid=1 only in DONE.
//   IDLE: on InValid at edge k: legal -> latch AluOp/AluA/AluB, go ISSUE;
//    illegal -> Error=1, Result=0, Zero=0, AluOp/AluA/AluB unchanged, go DONE.
//   ISSUE (one cycle, AluOp/AluA/AluB stable): at edge k+1 capture Result=AluRes,
//    Zero=(AluRes==0), Error=0, go DONE. Legal latency: OutValid high after edge k+1.
//   DONE: Result/Zero/Error stable while OutValid&!OutReady (indefinite stall OK).
//    On OutReady at edge: go IDLE; OpCount+=1 if Error=0 (wraps 2^CNT_W-1 -> 0).
//  No overlap: next request cannot be accepted in the edge that completes output;
//   back-to-back throughput = one op per 3 cycles (legal), 2 cycles (illegal).
//  AluA/AluB/AluOp hold last issued values outside ISSUE (no toggling when idle).
//  InA/InB/CtrlOp/Funct are don't-care when not accepted.
//  rst_n low mid-transaction: transaction dropped, all outputs to reset values
//   immediately, no partial result or count update.
//  Arithmetic is performed solely by the ALU; this block adds no width extension.
// TESTING
//  1 Reset: rst_n=0 mid-ISSUE -> OutValid=0, Result=0, OpCount=0 same cycle; InReady=1 one edge after release.
//  2 R-type ADD: Funct=0x20, InA=5, InB=7 -> AluOp=010 in ISSUE; Result=12, Zero=0, OutValid at accept+1 edge.
//  3 Branch SUB: CtrlOp=01, InA=InB=0x1234 -> AluOp=110, Result=0, Zero=1; SLT Funct=0x2A, 3 vs 9 -> Result per ALU, AluOp=111.
//  4 Illegal: CtrlOp=10, Funct=0x3F -> OutValid next edge, Error=1, Result=0; OpCount unchanged after handshake.
//  5 Backpressure: OutReady=0 for 10 cycles -> Result/Zero stable, InReady=0; InValid requests not accepted until IDLE.
//  6 Counter wrap: CNT_W=4, 16 legal ops -> OpCount 15 -> 0; AND 0xF0F0&0x0FF0 -> 0x00F0 with AluOp=000.

Source files
------------

// File: rtl/alu_sequencer.sv
// ALU request sequencer: decodes one op, issues it to the external ALU for a cycle, and returns the result.
// Latency: result valid after accept+1 edge (legal) or accept edge (illegal); output held until OutReady.
module alu_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             InValid,
  output logic             InReady,
  input  logic [1:0]       CtrlOp,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] InA,
  input  logic [WIDTH-1:0] InB,
  output logic [2:0]       AluOp,
  output logic [WIDTH-1:0] AluA,
  output logic [WIDTH-1:0] AluB,
  input  logic [WIDTH-1:0] AluRes,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [WIDTH-1:0] Result,
  output logic             Zero,
  output logic             Error,
  output logic [CNT_W-1:0] OpCount
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_started;
  logic [2:0]       r_alu_op;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_error;
  logic [CNT_W-1:0] r_count;

  logic [2:0]       w_dec_op;
  logic             w_dec_legal;
  logic             w_accept;
  logic             w_out_hs;

  always_comb begin
    w_dec_op    = 3'b010;
    w_dec_legal = 1'b1;
    case (CtrlOp)
      2'b00: w_dec_op = 3'b010;
      2'b01: w_dec_op = 3'b110;
      2'b10: begin
        case (Funct)
          6'h20:   w_dec_op = 3'b010;
          6'h22:   w_dec_op = 3'b110;
          6'h24:   w_dec_op = 3'b000;
          6'h25:   w_dec_op = 3'b001;
          6'h2A:   w_dec_op = 3'b111;
          default: w_dec_legal = 1'b0;
        endcase
      end
      default: w_dec_legal = 1'b0;
    endcase
  end

  // Ready is suppressed for the first edge after reset release.
  assign InReady  = r_started && (r_state == S_IDLE);
  assign OutValid = (r_state == S_DONE);
  assign w_accept = InValid && InReady;
  assign w_out_hs = OutValid && OutReady;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_dec_legal ? S_ISSUE : S_DONE;
      S_ISSUE: w_state_nxt = S_DONE;
      S_DONE:  if (OutReady) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_started <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_started <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alu_op <= 3'b010;
      r_alu_a  <= '0;
      r_alu_b  <= '0;
      r_result <= '0;
      r_zero   <= 1'b0;
      r_error  <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_accept) begin
        if (w_dec_legal) begin
          r_alu_op <= w_dec_op;
          r_alu_a  <= InA;
          r_alu_b  <= InB;
        end else begin
          r_result <= '0;
          r_zero   <= 1'b0;
          r_error  <= 1'b1;
        end
      end
      if (r_state == S_ISSUE) begin
        r_result <= AluRes;
        r_zero   <= (AluRes == '0);
        r_error  <= 1'b0;
      end
      if (w_out_hs && !r_error) begin
        r_count <= r_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end
  end

  assign AluOp   = r_alu_op;
  assign AluA    = r_alu_a;
  assign AluB    = r_alu_b;
  assign Result  = r_result;
  assign Zero    = r_zero;
  assign Error   = r_error;
  assign OpCount = r_count;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: table of ops plus wrap, backpressure and mid-transaction reset sequences.
module tb_alu_sequencer;
  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             InValid = 1'b0;
  logic             InReady;
  logic [1:0]       CtrlOp = 2'b00;
  logic [5:0]       Funct = 6'h00;
  logic [WIDTH-1:0] InA = '0;
  logic [WIDTH-1:0] InB = '0;
  logic [2:0]       AluOp;
  logic [WIDTH-1:0] AluA;
  logic [WIDTH-1:0] AluB;
  logic [WIDTH-1:0] AluRes;
  logic             OutValid;
  logic             OutReady = 1'b0;
  logic [WIDTH-1:0] Result;
  logic             Zero;
  logic             Error;
  logic [CNT_W-1:0] OpCount;

  alu_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .InValid(InValid), .InReady(InReady),
    .CtrlOp(CtrlOp), .Funct(Funct), .InA(InA), .InB(InB),
    .AluOp(AluOp), .AluA(AluA), .AluB(AluB), .AluRes(AluRes),
    .OutValid(OutValid), .OutReady(OutReady), .Result(Result),
    .Zero(Zero), .Error(Error), .OpCount(OpCount)
  );

  always #5 clk = ~clk;

  // Reference ALU: signed compare for SLT.
  always_comb begin
    AluRes = '0;
    case (AluOp)
      3'b000:  AluRes = AluA & AluB;
      3'b001:  AluRes = AluA | AluB;
      3'b010:  AluRes = AluA + AluB;
      3'b110:  AluRes = AluA - AluB;
      3'b111:  AluRes = ($signed(AluA) < $signed(AluB)) ? 32'd1 : 32'd0;
      default: AluRes = '0;
    endcase
  end

  typedef struct {
    logic [1:0]       ctrl;
    logic [5:0]       funct;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             err;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             err;
  } exp_t;

  exp_t       sb[$];
  vec_t       vecs[9];
  int         n_checks = 0;
  int         n_fail = 0;
  logic [2:0] last_op = 3'b010;
  logic [CNT_W-1:0] exp_cnt = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic run_op(input vec_t v, input int stall);
    exp_t e;
    int   n;
    n = 0;
    while (!InReady && n < 20) begin
      @(posedge clk); #1; n++;
    end
    chk("in_ready_wait", InReady, 1'b1);
    if (!InReady) return;
    CtrlOp = v.ctrl; Funct = v.funct; InA = v.a; InB = v.b; InValid = 1'b1;
    sb.push_back('{res: v.res, zero: v.zero, err: v.err});
    @(posedge clk); #1;
    InValid = 1'b0;
    if (!v.err) begin
      chk("issue_aluop", AluOp, v.op);
      chk("issue_alua", AluA, v.a);
      chk("issue_not_valid", OutValid, 1'b0);
      last_op = v.op;
      @(posedge clk); #1;
    end else begin
      chk("illegal_aluop_hold", AluOp, last_op);
    end
    chk("out_valid", OutValid, 1'b1);
    for (int i = 0; i < stall; i++) begin
      InValid = 1'b1; CtrlOp = 2'b00; InA = i; InB = 32'h55;
      @(posedge clk); #1;
      chk("stall_result", Result, v.res);
      chk("stall_zero", Zero, v.zero);
      chk("stall_in_ready", InReady, 1'b0);
      chk("stall_valid", OutValid, 1'b1);
    end
    InValid = 1'b0;
    OutReady = 1'b1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1'b1, 1'b0);
      return;
    end
    e = sb.pop_front();
    chk("result", Result, e.res);
    chk("zero", Zero, e.zero);
    chk("error", Error, e.err);
    @(posedge clk); #1;
    OutReady = 1'b0;
    if (!e.err) exp_cnt = exp_cnt + 1'b1;
    chk("valid_dropped", OutValid, 1'b0);
    chk("op_count", OpCount, exp_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    vecs[0] = '{2'b10, 6'h20, 32'd5,        32'd7,        3'b010, 32'd12,       1'b0, 1'b0};
    vecs[1] = '{2'b01, 6'h00, 32'h1234,     32'h1234,     3'b110, 32'd0,        1'b1, 1'b0};
    vecs[2] = '{2'b10, 6'h2A, 32'd3,        32'd9,        3'b111, 32'd1,        1'b0, 1'b0};
    vecs[3] = '{2'b10, 6'h24, 32'hF0F0,     32'h0FF0,     3'b000, 32'h00F0,     1'b0, 1'b0};
    vecs[4] = '{2'b10, 6'h3F, 32'd1,        32'd2,        3'b000, 32'd0,        1'b0, 1'b1};
    vecs[5] = '{2'b10, 6'h25, 32'hF000,     32'h000F,     3'b001, 32'hF00F,     1'b0, 1'b0};
    vecs[6] = '{2'b10, 6'h22, 32'd10,       32'd3,        3'b110, 32'd7,        1'b0, 1'b0};
    vecs[7] = '{2'b00, 6'h15, 32'hFFFFFFFF, 32'd1,        3'b010, 32'd0,        1'b1, 1'b0};
    vecs[8] = '{2'b11, 6'h20, 32'd4,        32'd4,        3'b010, 32'd0,        1'b0, 1'b1};

    #12;
    chk("rst_out_valid", OutValid, 1'b0);
    chk("rst_in_ready", InReady, 1'b0);
    chk("rst_aluop", AluOp, 3'b010);
    chk("rst_result", Result, 32'd0);
    chk("rst_count", OpCount, 4'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("in_ready_before_edge", InReady, 1'b0);
    @(posedge clk); #1;
    chk("in_ready_after_edge", InReady, 1'b1);

    for (int i = 0; i < 9; i++) run_op(vecs[i], 0);

    // Backpressure: ten stalled cycles with a competing request held.
    run_op('{2'b10, 6'h20, 32'd100, 32'd23, 3'b010, 32'd123, 1'b0, 1'b0}, 10);

    // Counter wrap: 16 legal adds return OpCount to its starting value, crossing 15 -> 0.
    for (int i = 0; i < 16; i++) begin
      v = '{2'b00, 6'h00, i, 3 * i, 3'b010, 4 * i, (i == 0), 1'b0};
      run_op(v, 0);
    end

    // Reset asserted while the op sits in ISSUE.
    while (!InReady) begin @(posedge clk); #1; end
    CtrlOp = 2'b10; Funct = 6'h20; InA = 32'd9; InB = 32'd9; InValid = 1'b1;
    @(posedge clk); #1;
    InValid = 1'b0;
    chk("pre_reset_issue", AluA, 32'd9);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", OutValid, 1'b0);
    chk("midrst_result", Result, 32'd0);
    chk("midrst_count", OpCount, 4'd0);
    chk("midrst_alua", AluA, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("midrst_ready_low", InReady, 1'b0);
    @(posedge clk); #1;
    chk("midrst_ready_high", InReady, 1'b1);
    chk("midrst_no_output", OutValid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
